// File: rtl/uart_rx_top.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_top
// Purpose  : UART receiver with 16x oversampling, an optional odd/even parity
//            bit and stop-bit (framing) check. Recovers 8N1/8[OE]1 frames
//            from an asynchronous serial line.
// Revision : 1.0  initial release
// ============================================================================
module uart_rx_top #(
  parameter int CLK_FREQ    = 50000000,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,        // active-high synchronous reset
  input  logic       data_rx,
  input  logic [1:0] parity_type,
  input  logic [1:0] baud_rate,
  output logic [7:0] data_out,
  output logic       active_flag,
  output logic       done_flag,
  output logic       parity_error,
  output logic       stop_error
);

  // Synchronizer depth is never allowed below two flops.
  localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  // Rounded oversample divisors, one per supported baud rate.
  localparam int DIV_2400  = (CLK_FREQ + 8 * 2400)  / (16 * 2400);
  localparam int DIV_4800  = (CLK_FREQ + 8 * 4800)  / (16 * 4800);
  localparam int DIV_9600  = (CLK_FREQ + 8 * 9600)  / (16 * 9600);
  localparam int DIV_19200 = (CLK_FREQ + 8 * 19200) / (16 * 19200);
  localparam int DIV_W     = $clog2(DIV_2400 + 1);

  // After reset the synchronizer still holds its preset ones; edge detection
  // stays disarmed until those have been flushed so that a line held low
  // through reset is not mistaken for a start bit.
  localparam int                 FLUSH_W   = $clog2(SYNC_N + 2);
  localparam logic [FLUSH_W-1:0] FLUSH_MAX = FLUSH_W'(SYNC_N + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [SYNC_N-1:0]  sync_q, sync_d;
  logic               rx_prev_q, rx_prev_d;
  logic [FLUSH_W-1:0] flush_q, flush_d;
  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic [3:0]         s_cnt_q, s_cnt_d;
  logic [2:0]         bit_cnt_q, bit_cnt_d;
  logic [7:0]         shift_q, shift_d;
  logic [1:0]         baud_q, baud_d;
  logic [1:0]         par_q, par_d;
  logic               par_err_q, par_err_d;
  logic [7:0]         data_out_q, data_out_d;
  logic               active_q, active_d;
  logic               done_q, done_d;
  logic               perr_q, perr_d;
  logic               serr_q, serr_d;

  logic               rx_s;
  logic               start_edge;
  logic               tick;
  logic               par_en;
  logic [DIV_W-1:0]   div_m1;

  assign rx_s       = sync_q[SYNC_N-1];
  assign start_edge = (flush_q == FLUSH_MAX) & rx_prev_q & ~rx_s;
  assign par_en     = (par_q == 2'b01) | (par_q == 2'b10);
  assign tick       = (div_cnt_q == div_m1);

  // Divisor selection from the baud rate latched at start detection.
  always_comb begin
    div_m1 = DIV_W'(DIV_2400 - 1);
    case (baud_q)
      2'b00:   div_m1 = DIV_W'(DIV_2400 - 1);
      2'b01:   div_m1 = DIV_W'(DIV_4800 - 1);
      2'b10:   div_m1 = DIV_W'(DIV_9600 - 1);
      default: div_m1 = DIV_W'(DIV_19200 - 1);
    endcase
  end

  // Input synchronizer, edge-detect history and post-reset flush counter.
  always_comb begin
    sync_d    = {sync_q[SYNC_N-2:0], data_rx};
    rx_prev_d = rx_s;
    flush_d   = (flush_q == FLUSH_MAX) ? flush_q : flush_q + FLUSH_W'(1);
  end

  // Receive FSM next-state, datapath and output logic.
  always_comb begin
    state_d    = state_q;
    s_cnt_d    = s_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    baud_d     = baud_q;
    par_d      = par_q;
    par_err_d  = par_err_q;
    data_out_d = data_out_q;
    active_d   = active_q;
    done_d     = 1'b0;
    perr_d     = perr_q;
    serr_d     = serr_q;
    div_cnt_d  = tick ? '0 : div_cnt_q + DIV_W'(1);

    case (state_q)
      S_IDLE: begin
        active_d = 1'b0;
        if (start_edge) begin
          // Align the oversample phase to the falling edge of the start bit.
          state_d   = S_START;
          active_d  = 1'b1;
          s_cnt_d   = 4'd0;
          bit_cnt_d = 3'd0;
          div_cnt_d = '0;
          baud_d    = baud_rate;
          par_d     = parity_type;
          par_err_d = 1'b0;
        end
      end

      S_START: begin
        if (tick) begin
          if (s_cnt_q == 4'd7) begin
            if (!rx_s) begin
              s_cnt_d   = 4'd0;
              bit_cnt_d = 3'd0;
              state_d   = S_DATA;
            end else begin
              // Line back high at mid start bit: a glitch, not a frame.
              state_d  = S_IDLE;
              active_d = 1'b0;
            end
          end else begin
            s_cnt_d = s_cnt_q + 4'd1;
          end
        end
      end

      S_DATA: begin
        if (tick) begin
          s_cnt_d = s_cnt_q + 4'd1;
          if (s_cnt_q == 4'd15) begin
            shift_d   = {rx_s, shift_q[7:1]};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              state_d = par_en ? S_PARITY : S_STOP;
            end
          end
        end
      end

      S_PARITY: begin
        if (tick) begin
          s_cnt_d = s_cnt_q + 4'd1;
          if (s_cnt_q == 4'd15) begin
            // Odd: total ones including parity must be odd; even: must be even.
            par_err_d = (par_q == 2'b01) ? ~(^{shift_q, rx_s}) : (^{shift_q, rx_s});
            state_d   = S_STOP;
          end
        end
      end

      S_STOP: begin
        if (tick) begin
          s_cnt_d = s_cnt_q + 4'd1;
          if (s_cnt_q == 4'd15) begin
            // Return to IDLE at mid stop bit so back-to-back starts are caught.
            data_out_d = shift_q;
            perr_d     = par_err_q;
            serr_d     = ~rx_s;
            done_d     = 1'b1;
            active_d   = 1'b0;
            state_d    = S_IDLE;
          end
        end
      end

      default: begin
        state_d  = S_IDLE;
        active_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q    <= S_IDLE;
      sync_q     <= '1;
      rx_prev_q  <= 1'b1;
      flush_q    <= '0;
      div_cnt_q  <= '0;
      s_cnt_q    <= 4'd0;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'h00;
      baud_q     <= 2'b00;
      par_q      <= 2'b00;
      par_err_q  <= 1'b0;
      data_out_q <= 8'h00;
      active_q   <= 1'b0;
      done_q     <= 1'b0;
      perr_q     <= 1'b0;
      serr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_q     <= sync_d;
      rx_prev_q  <= rx_prev_d;
      flush_q    <= flush_d;
      div_cnt_q  <= div_cnt_d;
      s_cnt_q    <= s_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      baud_q     <= baud_d;
      par_q      <= par_d;
      par_err_q  <= par_err_d;
      data_out_q <= data_out_d;
      active_q   <= active_d;
      done_q     <= done_d;
      perr_q     <= perr_d;
      serr_q     <= serr_d;
    end
  end

  assign data_out     = data_out_q;
  assign active_flag  = active_q;
  assign done_flag    = done_q;
  assign parity_error = perr_q;
  assign stop_error   = serr_q;

endmodule
`default_nettype wire
